// File: rtl/c2h_pack_sequencer.sv
// Streams one 4072-b packed word per packet as eight 512-b AXI-stream beats, pacing the packer with pack_en/pack_next.
// All outputs are registered; a presented beat holds while tready is low.
module c2h_pack_sequencer (
  input  logic          m_axis_c2h_aclk,
  input  logic          m_axis_c2h_aresetn,
  input  logic          start,
  input  logic          stop,
  input  logic [15:0]   pkt_limit,
  input  logic [4071:0] pack_data,
  input  logic          pack_valid,
  output logic          pack_en,
  output logic          pack_next,
  output logic [511:0]  m_axis_c2h_tdata,
  output logic [63:0]   m_axis_c2h_tkeep,
  output logic          m_axis_c2h_tvalid,
  input  logic          m_axis_c2h_tready,
  output logic          m_axis_c2h_tlast,
  output logic          busy,
  output logic [15:0]   pkt_count,
  output logic          overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_SEND,
    S_NEXT
  } state_t;

  localparam logic [63:0] KEEP_FULL = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] KEEP_LAST = 64'h1FFF_FFFF_FFFF_FFFF;

  state_t        state;
  logic [2:0]    beat;
  logic [15:0]   limit_q;
  logic          stop_pending;
  logic [4071:0] pkt_buf;
  logic [4095:0] buf_pad;
  logic [2:0]    beat_nxt;

  // Pad to a whole number of beats so the final beat reads zeros above bit 4071.
  assign buf_pad  = {24'd0, pkt_buf};
  assign beat_nxt = beat + 3'd1;

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state             <= S_IDLE;
      beat              <= '0;
      limit_q           <= '0;
      stop_pending      <= 1'b0;
      pkt_buf           <= '0;
      pack_en           <= 1'b0;
      pack_next         <= 1'b0;
      m_axis_c2h_tdata  <= '0;
      m_axis_c2h_tkeep  <= '0;
      m_axis_c2h_tvalid <= 1'b0;
      m_axis_c2h_tlast  <= 1'b0;
      busy              <= 1'b0;
      pkt_count         <= '0;
      overrun           <= 1'b0;
    end else begin
      pack_en   <= 1'b0;
      pack_next <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            limit_q <= pkt_limit;
            pack_en <= 1'b1;
            busy    <= 1'b1;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pkt_count    <= '0;
          overrun      <= pack_valid;
          stop_pending <= stop;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          // Ending the run wins over a packet offered in the same cycle.
          if (stop_pending || (limit_q != 16'd0 && pkt_count == limit_q)) begin
            stop_pending <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end else begin
            if (stop) stop_pending <= 1'b1;
            if (pack_valid) begin
              pkt_buf           <= pack_data;
              beat              <= '0;
              m_axis_c2h_tdata  <= pack_data[511:0];
              m_axis_c2h_tkeep  <= KEEP_FULL;
              m_axis_c2h_tlast  <= 1'b0;
              m_axis_c2h_tvalid <= 1'b1;
              state             <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (stop) stop_pending <= 1'b1;
          if (pack_valid) overrun <= 1'b1;
          if (m_axis_c2h_tready) begin
            if (beat == 3'd7) begin
              m_axis_c2h_tvalid <= 1'b0;
              m_axis_c2h_tlast  <= 1'b0;
              pack_next         <= 1'b1;
              state             <= S_NEXT;
            end else begin
              beat             <= beat_nxt;
              m_axis_c2h_tdata <= buf_pad[{beat_nxt, 9'd0} +: 512];
              m_axis_c2h_tkeep <= (beat_nxt == 3'd7) ? KEEP_LAST : KEEP_FULL;
              m_axis_c2h_tlast <= (beat_nxt == 3'd7);
            end
          end
        end
        S_NEXT: begin
          if (stop) stop_pending <= 1'b1;
          if (pack_valid) overrun <= 1'b1;
          if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
          state <= S_WAIT;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c2h_pack_sequencer.sv
// Directed bench: table of whole runs plus hand-written reset and start-collision sequences.
module tb_c2h_pack_sequencer;

  logic          m_axis_c2h_aclk = 1'b0;
  logic          m_axis_c2h_aresetn;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   pkt_limit = '0;
  logic [4071:0] pack_data = '0;
  logic          pack_valid = 1'b0;
  logic          pack_en;
  logic          pack_next;
  logic [511:0]  m_axis_c2h_tdata;
  logic [63:0]   m_axis_c2h_tkeep;
  logic          m_axis_c2h_tvalid;
  logic          m_axis_c2h_tready = 1'b1;
  logic          m_axis_c2h_tlast;
  logic          busy;
  logic [15:0]   pkt_count;
  logic          overrun;

  int total = 0;
  int bad = 0;

  always #5 m_axis_c2h_aclk = ~m_axis_c2h_aclk;

  c2h_pack_sequencer dut (
    .m_axis_c2h_aclk   (m_axis_c2h_aclk),
    .m_axis_c2h_aresetn(m_axis_c2h_aresetn),
    .start             (start),
    .stop              (stop),
    .pkt_limit         (pkt_limit),
    .pack_data         (pack_data),
    .pack_valid        (pack_valid),
    .pack_en           (pack_en),
    .pack_next         (pack_next),
    .m_axis_c2h_tdata  (m_axis_c2h_tdata),
    .m_axis_c2h_tkeep  (m_axis_c2h_tkeep),
    .m_axis_c2h_tvalid (m_axis_c2h_tvalid),
    .m_axis_c2h_tready (m_axis_c2h_tready),
    .m_axis_c2h_tlast  (m_axis_c2h_tlast),
    .busy              (busy),
    .pkt_count         (pkt_count),
    .overrun           (overrun)
  );

  typedef struct {
    logic [15:0] limit;
    bit          stall;
    int          stop_pkt;
    int          stop_beat;
    int          ovr_pkt;
    int          ovr_beat;
    int          exp_count;
    bit          exp_ovr;
  } run_vec_t;

  run_vec_t vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge m_axis_c2h_aclk);
    #1;
  endtask

  function automatic logic [4071:0] make_pkt(input int seed);
    logic [4071:0] d;
    for (int i = 0; i < 509; i++) d[i*8 +: 8] = 8'((seed * 37 + i * 11 + 5) & 255);
    d[7:0] = 8'(seed);
    return d;
  endfunction

  // Collects eight beats of one packet, checking framing, hold-while-stalled and byte-exact reassembly.
  task automatic recv_pkt(input int p, input logic [4071:0] pkt, input run_vec_t v);
    logic [4095:0] asm_q = '0;
    logic [4095:0] want;
    logic [511:0]  held_d = '0;
    logic [63:0]   held_k = '0;
    logic          held_l = 1'b0;
    int            got = 0;
    int            iters = 0;
    int            first_bad = -1;
    bit            stalled = 1'b0;
    bit            stop_done = 1'b0;
    bit            ovr_done = 1'b0;
    while (got < 8 && iters < 200) begin
      m_axis_c2h_tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      stop = 1'b0;
      pack_valid = 1'b0;
      pack_data = pkt;
      if (p == v.stop_pkt && got == v.stop_beat && !stop_done) begin
        stop = 1'b1;
        stop_done = 1'b1;
      end
      if (p == v.ovr_pkt && got == v.ovr_beat && !ovr_done) begin
        pack_valid = 1'b1;
        pack_data = ~pkt;
        ovr_done = 1'b1;
      end
      @(negedge m_axis_c2h_aclk);
      if (stalled) begin
        chk("hold_tvalid", 512'(m_axis_c2h_tvalid), 512'(1));
        chk("hold_tdata", m_axis_c2h_tdata, held_d);
        chk("hold_tkeep", 512'(m_axis_c2h_tkeep), 512'(held_k));
        chk("hold_tlast", 512'(m_axis_c2h_tlast), 512'(held_l));
      end
      stalled = m_axis_c2h_tvalid && !m_axis_c2h_tready;
      held_d = m_axis_c2h_tdata;
      held_k = m_axis_c2h_tkeep;
      held_l = m_axis_c2h_tlast;
      if (m_axis_c2h_tvalid && m_axis_c2h_tready) begin
        chk("tlast", 512'(m_axis_c2h_tlast), 512'(got == 7));
        chk("tkeep", 512'(m_axis_c2h_tkeep),
            (got == 7) ? 512'(64'h1FFF_FFFF_FFFF_FFFF) : 512'(64'hFFFF_FFFF_FFFF_FFFF));
        asm_q[got*512 +: 512] = m_axis_c2h_tdata;
        got++;
      end
      tick();
      iters++;
    end
    stop = 1'b0;
    pack_valid = 1'b0;
    chk("beats_received", 512'(got), 512'(8));
    if (!v.stall) chk("beat_latency", 512'(iters), 512'(8));
    want = {24'd0, pkt};
    total++;
    if (asm_q !== want) begin
      bad++;
      for (int k = 0; k < 512; k++)
        if (first_bad < 0 && asm_q[k*8 +: 8] !== want[k*8 +: 8]) first_bad = k;
      $display("FAIL reassembly pkt %0d: byte %0d got %0h expected %0h", p, first_bad,
               asm_q[first_bad*8 +: 8], want[first_bad*8 +: 8]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge m_axis_c2h_aclk);
    while (busy && n < 6) begin
      tick();
      @(negedge m_axis_c2h_aclk);
      n++;
    end
    chk("busy_falls", 512'(busy), 512'(0));
  endtask

  task automatic do_run(input run_vec_t v, input int salt);
    logic [4071:0] pkt;
    start = 1'b1;
    pkt_limit = v.limit;
    tick();
    start = 1'b0;
    @(negedge m_axis_c2h_aclk);
    chk("clear_pack_en", 512'(pack_en), 512'(1));
    chk("clear_busy", 512'(busy), 512'(1));
    tick();
    @(negedge m_axis_c2h_aclk);
    chk("wait_pack_en_low", 512'(pack_en), 512'(0));
    chk("wait_overrun_clr", 512'(overrun), 512'(0));
    chk("wait_count_clr", 512'(pkt_count), 512'(0));
    for (int p = 1; p <= v.exp_count; p++) begin
      pkt = make_pkt(salt + p);
      pack_data = pkt;
      pack_valid = 1'b1;
      tick();
      pack_valid = 1'b0;
      recv_pkt(p, pkt, v);
      @(negedge m_axis_c2h_aclk);
      chk("next_pack_next", 512'(pack_next), 512'(1));
      chk("next_pack_en", 512'(pack_en), 512'(0));
      chk("next_tvalid", 512'(m_axis_c2h_tvalid), 512'(0));
      tick();
      @(negedge m_axis_c2h_aclk);
      chk("wait_pack_next_low", 512'(pack_next), 512'(0));
      chk("pkt_count_step", 512'(pkt_count), 512'(p));
    end
    wait_idle();
    chk("run_pkt_count", 512'(pkt_count), 512'(v.exp_count));
    chk("run_overrun", 512'(overrun), 512'(v.exp_ovr));
    chk("idle_tvalid", 512'(m_axis_c2h_tvalid), 512'(0));
  endtask

  initial begin
    logic [4071:0] pkt;
    bit saw;
    //                 limit  stall stop_p stop_b ovr_p ovr_b exp ovr
    vecs[0] = '{16'd2, 1'b0, 0, 0, 0, 0, 2, 1'b0};
    vecs[1] = '{16'd3, 1'b1, 0, 0, 0, 0, 3, 1'b0};
    vecs[2] = '{16'd0, 1'b0, 5, 3, 0, 0, 5, 1'b0};
    vecs[3] = '{16'd1, 1'b0, 0, 0, 1, 2, 1, 1'b1};
    vecs[4] = '{16'd0, 1'b1, 1, 0, 0, 0, 1, 1'b0};
    vecs[5] = '{16'd2, 1'b1, 0, 0, 0, 0, 2, 1'b0};

    m_axis_c2h_aresetn = 1'b1;
    #1 m_axis_c2h_aresetn = 1'b0;
    #2;
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_tvalid", 512'(m_axis_c2h_tvalid), 512'(0));
    chk("rst_tdata", m_axis_c2h_tdata, 512'(0));
    chk("rst_tkeep", 512'(m_axis_c2h_tkeep), 512'(0));
    chk("rst_pack_en", 512'(pack_en), 512'(0));
    chk("rst_pkt_count", 512'(pkt_count), 512'(0));
    tick();
    tick();
    m_axis_c2h_aresetn = 1'b1;
    tick();
    @(negedge m_axis_c2h_aclk);
    chk("post_rst_idle", 512'(busy), 512'(0));

    for (int i = 0; i < 6; i++) do_run(vecs[i], 10 * (i + 1));

    // start and pack_valid together in IDLE: the packet is ignored, no overrun.
    start = 1'b1;
    pack_valid = 1'b1;
    pack_data = make_pkt(99);
    pkt_limit = 16'd0;
    tick();
    start = 1'b0;
    pack_valid = 1'b0;
    @(negedge m_axis_c2h_aclk);
    chk("collide_pack_en", 512'(pack_en), 512'(1));
    chk("collide_overrun", 512'(overrun), 512'(0));
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle();
    chk("collide_count", 512'(pkt_count), 512'(0));
    chk("collide_no_send", 512'(m_axis_c2h_tvalid), 512'(0));

    // Reset at beat 4 of the second packet.
    start = 1'b1;
    pkt_limit = 16'd0;
    tick();
    start = 1'b0;
    tick();
    m_axis_c2h_tready = 1'b1;
    pack_data = make_pkt(90);
    pack_valid = 1'b1;
    tick();
    pack_valid = 1'b0;
    repeat (8) tick();
    tick();
    @(negedge m_axis_c2h_aclk);
    chk("rstseq_count1", 512'(pkt_count), 512'(1));
    pkt = make_pkt(91);
    pack_data = pkt;
    pack_valid = 1'b1;
    tick();
    pack_valid = 1'b0;
    repeat (4) tick();
    @(negedge m_axis_c2h_aclk);
    chk("rstseq_beat4_vld", 512'(m_axis_c2h_tvalid), 512'(1));
    chk("rstseq_beat4_dat", m_axis_c2h_tdata, pkt[2559:2048]);
    #2 m_axis_c2h_aresetn = 1'b0;
    #1;
    chk("rstseq_tvalid", 512'(m_axis_c2h_tvalid), 512'(0));
    chk("rstseq_count0", 512'(pkt_count), 512'(0));
    chk("rstseq_busy", 512'(busy), 512'(0));
    chk("rstseq_tdata", m_axis_c2h_tdata, 512'(0));
    tick();
    tick();
    m_axis_c2h_aresetn = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge m_axis_c2h_aclk);
      if (m_axis_c2h_tvalid || busy || pack_next) saw = 1'b1;
      tick();
    end
    chk("rstseq_no_partial", 512'(saw), 512'(0));
    do_run(vecs[0], 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
